regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Integer register file for the RV32I core. It is the receiving end of the writeback interface: it consumes the write-enable, destination-address and write-data triple driven by the writeback stage.
- Provides two read ports to decode.
- Holds a per-register pending-write scoreboard. Decode uses it to stall on RAW hazards until the producing writeback lands.
- Sits between the decode stage (reads, issue) and the writeback stage (writes).

Parameters:
- XLEN, 32, data width of each architectural register.
- SB_CNT_W, 2, width of each per-register pending-writer counter; up to 2^SB_CNT_W-1 in-flight writers per register.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- i_rd_wen  input  1  writeback write enable.
- i_rd_addr  input  5  writeback destination register.
- i_rd_wdata  input  XLEN  writeback data.
- i_rs1_addr  input  5  read port 1 address.
- i_rs2_addr  input  5  read port 2 address.
- o_rs1_data  output  XLEN  read port 1 data (combinational).
- o_rs2_data  output  XLEN  read port 2 data (combinational).
- i_issue_valid  input  1  decode issues an instruction this cycle.
- i_issue_rd_wen  input  1  the issued instruction writes rd.
- i_issue_rd_addr  input  5  rd of the issued instruction.
- o_issue_ready  output  1  issue accepted; low when the target counter is saturated.
- o_rs1_busy  output  1  rs1 has a pending writer.
- o_rs2_busy  output  1  rs2 has a pending writer.
- i_flush  input  1  pipeline flush; clears the scoreboard.

Behaviour:
- Storage: x1..x31 are XLEN-bit flops. x0 reads 0 always; writes to x0 are discarded.
- Reset (async, rst=1): all registers = 0 and all scoreboard counters = 0. Outputs during reset: o_rs*_data=0, o_rs*_busy=0, o_issue_ready=1.
- Write: on the rising edge with i_rd_wen=1 and i_rd_addr!=0, reg[i_rd_addr] <= i_rd_wdata. Latency 1 cycle (value readable the next cycle without the bypass feature).
- Read: o_rsN_data = reg[i_rsN_addr] combinationally; 0 when the address is 0.
- Scoreboard: cnt[r] is SB_CNT_W bits, r=1..31; cnt[0] is constant 0.
  - Increment event (inc): i_issue_valid & i_issue_rd_wen & o_issue_ready & i_issue_rd_addr!=0.
  - Decrement event (dec): i_rd_wen & i_rd_addr!=0 & cnt[i_rd_addr]!=0. A writeback to a register whose counter is 0 (e.g. after a flush) writes data but leaves the counter at 0, with no underflow.
  - inc and dec on the same register in the same cycle: counter unchanged.
  - inc and dec on different registers in the same cycle: both apply.
- o_issue_ready = ~(i_issue_rd_wen & cnt[i_issue_rd_addr]==max). Combinational and independent of i_issue_valid. rd=x0 is always ready.
- o_rsN_busy = (cnt[i_rsN_addr]!=0). Without the bypass feature, a writeback to rsN in the current cycle does not clear busy until the next cycle.
- i_flush=1: all counters go to 0 at the edge, overriding inc/dec in that cycle. The register write in that cycle still occurs. Upstream guarantees that no unflushed older writer remains in flight when flush is asserted.
- Reset asserted mid-operation: state clears immediately. A write presented in the same cycle is lost.

Optional Feature:
- Macro: REGFILE_SB_BYPASS_EN.
- Defined:
  - Same-cycle forwarding: if i_rd_wen & i_rd_addr!=0 & i_rd_addr==i_rsN_addr, then o_rsN_data=i_rd_wdata.
  - o_rsN_busy is also suppressed when that writeback retires the last pending writer, i.e. the counter is 1 with no same-cycle inc to the same register.
- Undefined: reads return stored values only; busy follows the counter as registered. Decode sees one extra stall cycle per RAW hazard.

Test Plan:
- Reset, then read x0..x31 -> all 0; busy=0; issue_ready=1.
- Write x5=0xDEADBEEF, next cycle read rs1=x5 -> 0xDEADBEEF; write x0=0x1234 -> x0 still reads 0.
- Issue rd=x7, then rs2=x7 -> busy=1. Writeback x7=0x55 -> busy=0 next cycle, data 0x55. With REGFILE_SB_BYPASS_EN: busy=0 and data=0x55 in the writeback cycle itself.
- Three issues to x3 (SB_CNT_W=2) -> cnt=3; fourth issue -> o_issue_ready=0. One writeback to x3 -> ready=1 the next cycle.
- Same cycle: issue rd=x9 and writeback x9 while cnt=1 -> cnt stays 1, busy stays 1, x9 updated.
- Issue to x4 and x6, assert i_flush together with writeback x4=0xA -> all busy=0, x4=0xA. A later writeback x6 does not underflow (busy stays 0).

Source files
------------

// File: rtl/regfile_sb.sv
// RV32I integer register file with per-register pending-writer scoreboard for RAW stalls.
// Optional macro REGFILE_SB_BYPASS_EN: same-cycle writeback forwarding to read data and busy.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int SB_CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_rd_wen,
  input  logic [4:0]      i_rd_addr,
  input  logic [XLEN-1:0] i_rd_wdata,
  input  logic [4:0]      i_rs1_addr,
  input  logic [4:0]      i_rs2_addr,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  input  logic            i_issue_valid,
  input  logic            i_issue_rd_wen,
  input  logic [4:0]      i_issue_rd_addr,
  output logic            o_issue_ready,
  output logic            o_rs1_busy,
  output logic            o_rs2_busy,
  input  logic            i_flush
);

  localparam logic [SB_CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [SB_CNT_W-1:0] CNT_ONE  = SB_CNT_W'(1);
  localparam logic [SB_CNT_W-1:0] CNT_ZERO = '0;

  logic [XLEN-1:0]     regs_q [1:31];
  logic [XLEN-1:0]     regs_d [1:31];
  logic [SB_CNT_W-1:0] cnt_q  [1:31];
  logic [SB_CNT_W-1:0] cnt_d  [1:31];

  logic [XLEN-1:0]     rs1_reg, rs2_reg;
  logic [SB_CNT_W-1:0] rs1_cnt, rs2_cnt, iss_cnt, wb_cnt;
  logic                wr_en, inc, dec;

  // x0 has no storage; every lookup of address 0 yields zero data and a zero count.
  always_comb begin
    rs1_reg = '0;
    rs2_reg = '0;
    rs1_cnt = '0;
    rs2_cnt = '0;
    iss_cnt = '0;
    wb_cnt  = '0;
    if (i_rs1_addr != 5'd0) begin
      rs1_reg = regs_q[i_rs1_addr];
      rs1_cnt = cnt_q[i_rs1_addr];
    end
    if (i_rs2_addr != 5'd0) begin
      rs2_reg = regs_q[i_rs2_addr];
      rs2_cnt = cnt_q[i_rs2_addr];
    end
    if (i_issue_rd_addr != 5'd0) iss_cnt = cnt_q[i_issue_rd_addr];
    if (i_rd_addr != 5'd0)       wb_cnt  = cnt_q[i_rd_addr];
  end

  assign wr_en         = i_rd_wen & (i_rd_addr != 5'd0);
  assign o_issue_ready = ~(i_issue_rd_wen & (iss_cnt == CNT_MAX));
  assign inc           = i_issue_valid & i_issue_rd_wen & o_issue_ready & (i_issue_rd_addr != 5'd0);
  assign dec           = wr_en & (wb_cnt != CNT_ZERO);

  always_comb begin
    for (int r = 1; r < 32; r++) begin
      regs_d[r] = regs_q[r];
      cnt_d[r]  = cnt_q[r];
      if (wr_en && (i_rd_addr == 5'(r))) regs_d[r] = i_rd_wdata;
      if (i_flush) begin
        cnt_d[r] = CNT_ZERO;
      end else if (inc && (i_issue_rd_addr == 5'(r)) && !(dec && (i_rd_addr == 5'(r)))) begin
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (dec && (i_rd_addr == 5'(r)) && !(inc && (i_issue_rd_addr == 5'(r)))) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < 32; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
    end else begin
      for (int r = 1; r < 32; r++) begin
        regs_q[r] <= regs_d[r];
        cnt_q[r]  <= cnt_d[r];
      end
    end
  end

`ifdef REGFILE_SB_BYPASS_EN
  logic fwd1, fwd2, retire1, retire2;

  // Forwarding is masked during reset so the read ports stay at zero.
  always_comb begin
    fwd1       = ~rst & wr_en & (i_rd_addr == i_rs1_addr);
    fwd2       = ~rst & wr_en & (i_rd_addr == i_rs2_addr);
    retire1    = fwd1 & (rs1_cnt == CNT_ONE) & ~(inc & (i_issue_rd_addr == i_rs1_addr));
    retire2    = fwd2 & (rs2_cnt == CNT_ONE) & ~(inc & (i_issue_rd_addr == i_rs2_addr));
    o_rs1_data = fwd1 ? i_rd_wdata : rs1_reg;
    o_rs2_data = fwd2 ? i_rd_wdata : rs2_reg;
    o_rs1_busy = (rs1_cnt != CNT_ZERO) & ~retire1;
    o_rs2_busy = (rs2_cnt != CNT_ZERO) & ~retire2;
  end
`else
  assign o_rs1_data = rs1_reg;
  assign o_rs2_data = rs2_reg;
  assign o_rs1_busy = (rs1_cnt != CNT_ZERO);
  assign o_rs2_busy = (rs2_cnt != CNT_ZERO);
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: per-cycle stimulus with expected read/busy/ready pushed on drive.
module tb_regfile_sb;

`ifdef REGFILE_SB_BYPASS_EN
  localparam bit B = 1'b1;
`else
  localparam bit B = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rd_wen;
  logic [4:0]  i_rd_addr;
  logic [31:0] i_rd_wdata;
  logic [4:0]  i_rs1_addr, i_rs2_addr;
  logic [31:0] o_rs1_data, o_rs2_data;
  logic        i_issue_valid, i_issue_rd_wen;
  logic [4:0]  i_issue_rd_addr;
  logic        o_issue_ready, o_rs1_busy, o_rs2_busy;
  logic        i_flush;

  regfile_sb #(.XLEN(32), .SB_CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .i_rd_wen(i_rd_wen), .i_rd_addr(i_rd_addr), .i_rd_wdata(i_rd_wdata),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
    .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
    .i_issue_valid(i_issue_valid), .i_issue_rd_wen(i_issue_rd_wen),
    .i_issue_rd_addr(i_issue_rd_addr), .o_issue_ready(o_issue_ready),
    .o_rs1_busy(o_rs1_busy), .o_rs2_busy(o_rs2_busy), .i_flush(i_flush)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        iv;
    logic        iwen;
    logic [4:0]  iaddr;
    logic        flush;
  } stim_t;

  logic [66:0] exp_q[$];
  logic [66:0] obs, want;
  int nvec = 0;
  int nerr = 0;

  function automatic stim_t st(input logic r, input logic wen, input logic [4:0] wa,
                               input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2,
                               input logic iv, input logic iwen, input logic [4:0] ia,
                               input logic fl);
    st = '{rst: r, wen: wen, waddr: wa, wdata: wd, rs1: a1, rs2: a2,
           iv: iv, iwen: iwen, iaddr: ia, flush: fl};
  endfunction

  function automatic logic [66:0] mk(input logic [31:0] d1, input logic [31:0] d2,
                                     input logic b1, input logic b2, input logic rdy);
    mk = {d1, d2, b1, b2, rdy};
  endfunction

  task automatic apply(input stim_t s);
    rst             = s.rst;
    i_rd_wen        = s.wen;
    i_rd_addr       = s.waddr;
    i_rd_wdata      = s.wdata;
    i_rs1_addr      = s.rs1;
    i_rs2_addr      = s.rs2;
    i_issue_valid   = s.iv;
    i_issue_rd_wen  = s.iwen;
    i_issue_rd_addr = s.iaddr;
    i_flush         = s.flush;
  endtask

  task automatic test_reset();
    stim_t s[$];
    for (int a = 0; a < 32; a++) begin
      s.push_back(st(1, 1, 5'(a), 32'hFFFF_FFFF, 5'(a), 5'(31 - a), 1, 1, 5'(a), 0));
      exp_q.push_back(mk(32'h0, 32'h0, 0, 0, 1));
    end
    foreach (s[i]) begin
      apply(s[i]);
      #2;
      obs  = {o_rs1_data, o_rs2_data, o_rs1_busy, o_rs2_busy, o_issue_ready};
      want = exp_q.pop_front();
      nvec++;
      if (obs !== want) begin
        nerr++;
        $display("FAIL reset step %0d: got %h want %h", i, obs, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_write();
    stim_t s[$];
    s.push_back(st(0, 1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(B ? 32'hDEADBEEF : 32'h0, 32'h0, 0, 0, 1));
    s.push_back(st(0, 1, 0, 32'h1234, 5, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(32'hDEADBEEF, 32'h0, 0, 0, 1));
    s.push_back(st(0, 0, 0, 32'h0, 0, 5, 0, 0, 0, 0));
    exp_q.push_back(mk(32'h0, 32'hDEADBEEF, 0, 0, 1));
    foreach (s[i]) begin
      apply(s[i]);
      #2;
      obs  = {o_rs1_data, o_rs2_data, o_rs1_busy, o_rs2_busy, o_issue_ready};
      want = exp_q.pop_front();
      nvec++;
      if (obs !== want) begin
        nerr++;
        $display("FAIL write step %0d: got %h want %h", i, obs, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_raw();
    stim_t s[$];
    s.push_back(st(0, 0, 0, 0, 0, 7, 1, 1, 7, 0));
    exp_q.push_back(mk(32'h0, 32'h0, 0, 0, 1));
    s.push_back(st(0, 0, 0, 0, 7, 7, 0, 0, 0, 0));
    exp_q.push_back(mk(32'h0, 32'h0, 1, 1, 1));
    s.push_back(st(0, 1, 7, 32'h55, 7, 7, 0, 0, 0, 0));
    exp_q.push_back(mk(B ? 32'h55 : 32'h0, B ? 32'h55 : 32'h0, !B, !B, 1));
    s.push_back(st(0, 0, 0, 0, 7, 7, 0, 0, 0, 0));
    exp_q.push_back(mk(32'h55, 32'h55, 0, 0, 1));
    foreach (s[i]) begin
      apply(s[i]);
      #2;
      obs  = {o_rs1_data, o_rs2_data, o_rs1_busy, o_rs2_busy, o_issue_ready};
      want = exp_q.pop_front();
      nvec++;
      if (obs !== want) begin
        nerr++;
        $display("FAIL raw step %0d: got %h want %h", i, obs, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_saturate();
    stim_t s[$];
    s.push_back(st(0, 0, 0, 0, 3, 0, 1, 1, 3, 0));
    exp_q.push_back(mk(32'h0, 32'h0, 0, 0, 1));
    s.push_back(st(0, 0, 0, 0, 3, 0, 1, 1, 3, 0));
    exp_q.push_back(mk(32'h0, 32'h0, 1, 0, 1));
    s.push_back(st(0, 0, 0, 0, 3, 0, 1, 1, 3, 0));
    exp_q.push_back(mk(32'h0, 32'h0, 1, 0, 1));
    s.push_back(st(0, 0, 0, 0, 3, 0, 1, 1, 3, 0));
    exp_q.push_back(mk(32'h0, 32'h0, 1, 0, 0));
    s.push_back(st(0, 1, 3, 32'h33, 3, 3, 0, 1, 3, 0));
    exp_q.push_back(mk(B ? 32'h33 : 32'h0, B ? 32'h33 : 32'h0, 1, 1, 0));
    s.push_back(st(0, 0, 0, 0, 3, 3, 0, 1, 3, 0));
    exp_q.push_back(mk(32'h33, 32'h33, 1, 1, 1));
    s.push_back(st(0, 1, 3, 32'h33, 3, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(32'h33, 32'h0, 1, 0, 1));
    s.push_back(st(0, 1, 3, 32'h33, 3, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(32'h33, 32'h0, !B, 0, 1));
    s.push_back(st(0, 0, 0, 0, 3, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(32'h33, 32'h0, 0, 0, 1));
    foreach (s[i]) begin
      apply(s[i]);
      #2;
      obs  = {o_rs1_data, o_rs2_data, o_rs1_busy, o_rs2_busy, o_issue_ready};
      want = exp_q.pop_front();
      nvec++;
      if (obs !== want) begin
        nerr++;
        $display("FAIL saturate step %0d: got %h want %h", i, obs, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_same_cycle();
    stim_t s[$];
    s.push_back(st(0, 0, 0, 0, 9, 0, 1, 1, 9, 0));
    exp_q.push_back(mk(32'h0, 32'h0, 0, 0, 1));
    s.push_back(st(0, 1, 9, 32'h99, 9, 0, 1, 1, 9, 0));
    exp_q.push_back(mk(B ? 32'h99 : 32'h0, 32'h0, 1, 0, 1));
    s.push_back(st(0, 0, 0, 0, 9, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(32'h99, 32'h0, 1, 0, 1));
    s.push_back(st(0, 1, 9, 32'h99, 9, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(32'h99, 32'h0, !B, 0, 1));
    s.push_back(st(0, 0, 0, 0, 9, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(32'h99, 32'h0, 0, 0, 1));
    foreach (s[i]) begin
      apply(s[i]);
      #2;
      obs  = {o_rs1_data, o_rs2_data, o_rs1_busy, o_rs2_busy, o_issue_ready};
      want = exp_q.pop_front();
      nvec++;
      if (obs !== want) begin
        nerr++;
        $display("FAIL same_cycle step %0d: got %h want %h", i, obs, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    stim_t s[$];
    s.push_back(st(0, 0, 0, 0, 4, 6, 1, 1, 4, 0));
    exp_q.push_back(mk(32'h0, 32'h0, 0, 0, 1));
    s.push_back(st(0, 0, 0, 0, 4, 6, 1, 1, 6, 0));
    exp_q.push_back(mk(32'h0, 32'h0, 1, 0, 1));
    s.push_back(st(0, 1, 4, 32'hA, 4, 6, 0, 0, 0, 1));
    exp_q.push_back(mk(B ? 32'hA : 32'h0, 32'h0, !B, 1, 1));
    s.push_back(st(0, 0, 0, 0, 4, 6, 0, 0, 0, 0));
    exp_q.push_back(mk(32'hA, 32'h0, 0, 0, 1));
    s.push_back(st(0, 1, 6, 32'h66, 4, 6, 0, 0, 0, 0));
    exp_q.push_back(mk(32'hA, B ? 32'h66 : 32'h0, 0, 0, 1));
    s.push_back(st(0, 0, 0, 0, 4, 6, 0, 1, 6, 0));
    exp_q.push_back(mk(32'hA, 32'h66, 0, 0, 1));
    foreach (s[i]) begin
      apply(s[i]);
      #2;
      obs  = {o_rs1_data, o_rs2_data, o_rs1_busy, o_rs2_busy, o_issue_ready};
      want = exp_q.pop_front();
      nvec++;
      if (obs !== want) begin
        nerr++;
        $display("FAIL flush step %0d: got %h want %h", i, obs, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    stim_t s[$];
    s.push_back(st(0, 1, 11, 32'h77, 10, 11, 1, 1, 10, 0));
    exp_q.push_back(mk(32'h0, B ? 32'h77 : 32'h0, 0, 0, 1));
    s.push_back(st(0, 0, 0, 0, 10, 11, 0, 0, 0, 0));
    exp_q.push_back(mk(32'h0, 32'h77, 1, 0, 1));
    s.push_back(st(1, 1, 12, 32'hCC, 10, 12, 0, 0, 0, 0));
    exp_q.push_back(mk(32'h0, 32'h0, 0, 0, 1));
    s.push_back(st(0, 0, 0, 0, 11, 12, 0, 1, 10, 0));
    exp_q.push_back(mk(32'h0, 32'h0, 0, 0, 1));
    foreach (s[i]) begin
      apply(s[i]);
      #2;
      obs  = {o_rs1_data, o_rs2_data, o_rs1_busy, o_rs2_busy, o_issue_ready};
      want = exp_q.pop_front();
      nvec++;
      if (obs !== want) begin
        nerr++;
        $display("FAIL reset_mid step %0d: got %h want %h", i, obs, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[$];
    logic [31:0] d, prev;
    prev = 32'h0;
    for (int r = 1; r < 32; r++) begin
      d = 32'h1000_0000 + 32'(r) * 32'h0001_0011;
      s.push_back(st(0, 1, 5'(r), d, 5'(r - 1), 5'(r), 0, 0, 0, 0));
      exp_q.push_back(mk(prev, B ? d : 32'h0, 0, 0, 1));
      prev = d;
    end
    foreach (s[i]) begin
      apply(s[i]);
      #2;
      obs  = {o_rs1_data, o_rs2_data, o_rs1_busy, o_rs2_busy, o_issue_ready};
      want = exp_q.pop_front();
      nvec++;
      if (obs !== want) begin
        nerr++;
        $display("FAIL back_to_back step %0d: got %h want %h", i, obs, want);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    test_reset();
    test_write();
    test_raw();
    test_saturate();
    test_same_cycle();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
